// File: rtl/compute_s_pkg.sv
// compute_s_pkg: shared IDCT state enumeration, constants and 8x8 coefficient table
// Table entry k*8+r holds C[k][r], 13-bit signed, scaled by 2048.
package compute_s_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int N_READS = 512;
  localparam int SHIFT = 16;
  localparam int PIX_MAX = 255;
  localparam logic signed [12:0] COEFF [64] = '{
     13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,
     13'sd2008,  13'sd1702,  13'sd1137,   13'sd399,  -13'sd399, -13'sd1137, -13'sd1702, -13'sd2008,
     13'sd1892,   13'sd783,  -13'sd783, -13'sd1892, -13'sd1892,  -13'sd783,   13'sd783,  13'sd1892,
     13'sd1702,  -13'sd399, -13'sd2008, -13'sd1137,  13'sd1137,  13'sd2008,   13'sd399, -13'sd1702,
     13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,
     13'sd1137, -13'sd2008,   13'sd399,  13'sd1702, -13'sd1702,  -13'sd399,  13'sd2008, -13'sd1137,
      13'sd783, -13'sd1892,  13'sd1892,  -13'sd783,  -13'sd783,  13'sd1892, -13'sd1892,   13'sd783,
      13'sd399, -13'sd1137,  13'sd1702, -13'sd2008,  13'sd2008, -13'sd1702,  13'sd1137,  -13'sd399
  };
endpackage

// File: rtl/compute_s_coeff_rom.sv
// idct_coeff_rom: combinational C[k][r] lookup
// Ports: index = k*8+r (6 bits), coeff = signed 13-bit coefficient.
module idct_coeff_rom
  import compute_s_pkg::*;
(
  input  logic [5:0]         index,
  output logic signed [12:0] coeff
);
  assign coeff = COEFF[index];
endmodule

// File: rtl/compute_s.sv
// compute_s: one 8x8 S block = clip(floor(C^T * T / 2^16)) written as packed pixel pairs
// Ports: clock/resetn (sync, active low); compute_s_start request; compute_s_finish done pulse;
// t_address/t_read_data T RAM read port (1-cycle latency); s_address/s_write_data/s_write_enable S RAM write port.
module compute_s
  import compute_s_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               compute_s_start,
  output logic               compute_s_finish,
  output logic [5:0]         t_address,
  input  logic signed [31:0] t_read_data,
  output logic [4:0]         s_address,
  output logic [15:0]        s_write_data,
  output logic               s_write_enable
);
  state_t state, state_n;
  logic [9:0] cnt;
  logic [5:0] rd;
  logic [8:0] ac;
  logic signed [12:0] coeff;
  logic signed [47:0] acc, prod, sum, shifted;
  logic [7:0] clip, s_even;
  logic acc_en;
  // cnt equals the cycle number of the coming edge; reads lead accumulation by two cycles
  assign rd = 6'(cnt - 10'd1);
  assign ac = 9'(cnt - 10'd3);
  assign acc_en = (state == RUN && cnt >= 10'd3) || (state == DONE && cnt <= 10'(N_READS + 2));
  idct_coeff_rom rom (.index({ac[2:0], ac[8:6]}), .coeff(coeff));
  always_comb begin
    prod = 48'(t_read_data) * 48'(coeff);
    sum = (ac[2:0] == 3'd0 ? 48'sd0 : acc) + prod;
    shifted = sum >>> SHIFT;
    clip = shifted < 0 ? 8'd0 : shifted > PIX_MAX ? 8'(PIX_MAX) : shifted[7:0];
  end
  always_comb
    state_n = state == IDLE ? (compute_s_start && !compute_s_finish ? RUN : IDLE) :
              state == RUN  ? (cnt == 10'(N_READS) ? DONE : RUN) :
                              (cnt == 10'(N_READS + 3) ? IDLE : DONE);
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      s_even <= '0;
      t_address <= '0;
      s_address <= '0;
      s_write_data <= '0;
      s_write_enable <= 1'b0;
      compute_s_finish <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == IDLE ? 10'd1 : cnt + 10'd1;
      compute_s_finish <= state == DONE && cnt == 10'(N_READS + 3);
      s_write_enable <= 1'b0;
      if (state == RUN) t_address <= {rd[2:0], rd[5:3]};
      if (acc_en) begin
        acc <= sum;
        if (ac[2:0] == 3'd7) begin
          if (ac[3]) begin
            s_write_enable <= 1'b1;
            s_address <= {ac[8:6], ac[5:4]};
            s_write_data <= {s_even, clip};
          end else begin
            s_even <= clip;
          end
        end
      end
    end
  end
endmodule
